if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock clk_i, reset rst_ni.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- imem_req_o  out  1  instruction fetch request, single cycle.
- imem_addr_o  out  32  fetch address, valid with imem_req_o.
- imem_rvalid_i  in  1  fetch response valid.
- imem_rdata_i  in  32  fetch response data.
- stall_i  in  1  decode stall (load-use hazard).
- jump_i  in  1  redirect from execute (taken branch/jump).
- jump_addr_i  in  32  redirect target.
- inst_o  out  32  instruction to decode.
- inst_addr_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o holds a real instruction.

Function
REQ-004 The block SHALL keep at most one fetch outstanding; imem_req_o SHALL assert only when none is outstanding, or in the cycle the outstanding one returns.
REQ-005 Memory latency SHALL be any value >= 1 cycle after the request; the block SHALL tolerate latency 1 with back-to-back requests (one instruction per cycle).
REQ-006 The block SHALL drive imem_addr_o[1:0] as 2'b00 at all times.
REQ-007 FSM states SHALL be IDLE (no request outstanding), WAIT (request outstanding), HOLD (response buffered under stall).
REQ-008 IDLE SHALL issue a request at pc and go to WAIT, unless stall_i=1 and inst_valid_o=1, in which case it SHALL stay in IDLE.
REQ-009 In WAIT with imem_rvalid_i=1 and stall_i=0, the block SHALL register inst_o=imem_rdata_i, inst_addr_o=pc, inst_valid_o=1, set pc=pc+4 (mod 2^32), and issue the next request in the same cycle.
REQ-010 In WAIT with imem_rvalid_i=1 and stall_i=1, the block SHALL store the response in a one-entry buffer, hold inst_o/inst_addr_o/inst_valid_o, issue no request, and go to HOLD.
REQ-011 HOLD SHALL issue no request while stall_i=1; in the first cycle with stall_i=0, the block SHALL load the buffer into inst_o/inst_addr_o at the edge, issue a request for the next pc in that cycle, and go to WAIT.
REQ-012 While stall_i=1 in any state, inst_o, inst_addr_o and inst_valid_o SHALL hold their values.
REQ-013 On jump_i=1 the block SHALL, at the edge: set inst_o=32'h0000_0013 (NOP), inst_valid_o=0, clear the buffer, and set pc={jump_addr_i[31:2],2'b00}.
REQ-014 jump_i SHALL take priority over stall_i and imem_rvalid_i in the same cycle.
REQ-015 A jump while in WAIT with no response that cycle SHALL set a kill flag; the next response SHALL be discarded, then the target request SHALL be issued in that cycle.
REQ-016 With nothing left outstanding after a jump, the target request SHALL be issued in the cycle after jump_i.
REQ-017 A response arriving in the jump cycle itself SHALL be discarded with no kill flag set.
REQ-018 While inst_valid_o=0, inst_o SHALL equal the NOP encoding.

Reset
REQ-019 On rst_ni=0 the block SHALL asynchronously set pc=RESET_PC, state=IDLE, kill=0, buffer empty, inst_o=NOP, inst_addr_o=0, inst_valid_o=0; imem_req_o SHALL be 0 while reset is asserted.
REQ-020 A response to a request made before reset SHALL NOT be presented after reset; an rvalid in IDLE SHALL be ignored.
REQ-021 The first request after reset deassertion SHALL be issued in the first cycle after release, at RESET_PC.

Structure
REQ-022 The NOP encoding, ADDR_WIDTH/DATA_WIDTH and the FSM state encoding SHALL come from the shared defines file.
REQ-023 The block SHALL be a single module with no sub-modules; the one-entry buffer SHALL be inline registers.

Verification
REQ-024 Latency-1 memory, no stall or jump: the bench SHALL observe inst_addr_o = 0,4,8,12 on consecutive cycles, with inst_valid_o=1 from cycle 2.
REQ-025 stall_i high for 3 cycles while a response for addr 0x10 arrives: inst_o SHALL hold at 0x0C's instruction; 0x10 SHALL appear on the first cycle after release; no request SHALL issue while stalled.
REQ-026 Latency-3 memory, jump_i to 0x200 one cycle after the request for 0x20: the 0x20 response SHALL be dropped, the next request SHALL be at 0x200, and inst_valid_o=0 in between.
REQ-027 jump_i, stall_i and imem_rvalid_i all high in the same cycle, jump_addr_i=0x103: pc SHALL become 0x100, the buffer SHALL be empty, and inst_o SHALL be NOP.
REQ-028 rst_ni pulled low mid-WAIT with a late rvalid arriving during reset: after release, the first request SHALL be at RESET_PC and the stale data SHALL never appear on inst_o.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
//   Shared definitions for the instruction fetch stage: datapath widths, the
//   NOP encoding presented to decode when no real instruction is available,
//   the fetch FSM state encoding and a word-alignment helper.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [DATA_WIDTH-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding
    S_WAIT = 2'd1,  // one request outstanding
    S_HOLD = 2'd2   // response parked in the buffer while decode stalls
  } fetch_state_e;

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Single-outstanding instruction fetch stage. Issues word-aligned requests to
//   instruction memory, presents each returned word to decode together with its
//   PC, parks one response while decode is stalled, and handles redirects from
//   execute by squashing whatever is in flight.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   imem_req_o       single-cycle fetch request
//   imem_addr_o      fetch address (bits [1:0] always zero)
//   imem_rvalid_i    fetch response valid
//   imem_rdata_i     fetch response data
//   stall_i          decode stall, freezes the decode-facing outputs
//   jump_i           redirect from execute, highest priority
//   jump_addr_i      redirect target (low two bits ignored)
//   inst_o           instruction to decode (NOP when not valid)
//   inst_addr_o      PC of inst_o
//   inst_valid_o     inst_o holds a real instruction
// -----------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic                  inst_valid_o
);

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

  fetch_state_e state_q, state_d;

  // pc_q is the address of the outstanding request in WAIT, the address of the
  // buffered word in HOLD, and the next address to fetch in IDLE (or in WAIT
  // while a killed response is still pending).
  logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
  logic                  kill_q,      kill_d;
  logic [DATA_WIDTH-1:0] buf_q,       buf_d;
  logic [DATA_WIDTH-1:0] inst_q,      inst_d;
  logic [ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic                  inst_valid_q, inst_valid_d;

  logic                  req;
  logic [ADDR_WIDTH-1:0] req_addr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    buf_d        = buf_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;
    req          = 1'b0;
    req_addr     = pc_q;

    if (jump_i) begin
      // Redirect wins over stall and response. A request still in flight is
      // remembered via kill so its data is dropped when it finally returns;
      // a response landing in this very cycle is simply ignored.
      inst_d       = NOP;
      inst_valid_d = 1'b0;
      buf_d        = '0;
      pc_d         = word_align(jump_addr_i);
      if (state_q == S_WAIT && !imem_rvalid_i) begin
        state_d = S_WAIT;
        kill_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Refetch is pointless while decode is stalled on a valid word.
          if (!(stall_i && inst_valid_q)) begin
            req     = 1'b1;
            state_d = S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (kill_q) begin
              // Drop the stale word and go after the redirect target now.
              kill_d = 1'b0;
              req    = 1'b1;
            end else if (stall_i) begin
              buf_d   = imem_rdata_i;
              state_d = S_HOLD;
            end else begin
              inst_d       = imem_rdata_i;
              inst_addr_d  = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + WORD_BYTES;
              req          = 1'b1;
              req_addr     = pc_q + WORD_BYTES;
            end
          end
        end

        S_HOLD: begin
          if (!stall_i) begin
            inst_d       = buf_q;
            inst_addr_d  = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + WORD_BYTES;
            req          = 1'b1;
            req_addr     = pc_q + WORD_BYTES;
            state_d      = S_WAIT;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      // NOTE: the one-entry buffer is a plain register, so it is reset along
      // with the rest of the state; it is not a memory array.
      buf_q        <= '0;
      inst_q       <= NOP;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      buf_q        <= buf_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // The FSM sits in IDLE during reset; gating keeps the request quiet until
  // release so the first fetch lands in the first cycle afterwards.
  assign imem_req_o   = req & rst_ni;
  assign imem_addr_o  = word_align(req_addr);
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;

endmodule
